// File: rtl/fpu_pkg.sv
// Shared FP16 constants and enums for the FPU execution units.
package fpu_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int BIAS   = 15;

  localparam logic [15:0] FP16_POS_INF = 16'h7C00;
  localparam logic [15:0] FP16_QNAN    = 16'h7E00;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_DIV  = 3'd3,
    OP_CONV = 3'd4
  } fpu_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'd0,
    DIV_UNPACK = 2'd1,
    DIV_DIVIDE = 2'd2,
    DIV_ROUND  = 2'd3
  } div_state_e;

endpackage

// File: rtl/fpu_fp16_classify.sv
// Combinational FP16 field split and operand classification.
module fpu_fp16_classify
  import fpu_pkg::*;
(
  input  logic [15:0]       x,
  output logic              is_zero,
  output logic              is_inf,
  output logic              is_nan,
  output logic              is_sub,
  output logic              sign,
  output logic [EXP_W-1:0]  exp,
  output logic [FRAC_W:0]   mant
);

  logic [FRAC_W-1:0] frac;
  logic              exp_zero;
  logic              exp_ones;

  assign sign     = x[15];
  assign exp      = x[14:10];
  assign frac     = x[9:0];
  assign exp_zero = (exp == '0);
  assign exp_ones = (exp == '1);

  assign is_zero  = exp_zero & (frac == '0);
  assign is_sub   = exp_zero & (frac != '0);
  assign is_inf   = exp_ones & (frac == '0);
  assign is_nan   = exp_ones & (frac != '0);
  // hidden bit only for normals; zero/subnormal are flushed by the caller
  assign mant     = {~exp_zero, frac};

endmodule

// File: rtl/fpu_div_iterative.sv
// FP16 divider: restoring division, one quotient bit per cycle, RNE rounding,
// flush-to-zero on subnormal inputs and outputs. One operation in flight.
module fpu_div_iterative
  import fpu_pkg::*;
#(
  parameter logic [15:0] NAN_VALUE = FP16_QNAN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        valid_out,
  output logic [15:0] result,
  output logic        busy
);

  div_state_e         state;
  logic [15:0]        a_q, b_q;
  logic               sign_q;
  logic signed [6:0]  exp_q;
  logic [10:0]        mb_q;
  logic [11:0]        rem_q;
  logic [13:0]        q_q;
  logic [3:0]         cnt_q;
  logic               spec_q;
  logic [15:0]        spec_val_q;

  logic              a_zero, a_inf, a_nan, a_sub, a_sign;
  logic              b_zero, b_inf, b_nan, b_sub, b_sign;
  logic [4:0]        a_exp, b_exp;
  logic [10:0]       a_mant, b_mant;

  fpu_fp16_classify u_cls_a (
    .x(a_q), .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan), .is_sub(a_sub),
    .sign(a_sign), .exp(a_exp), .mant(a_mant)
  );
  fpu_fp16_classify u_cls_b (
    .x(b_q), .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan), .is_sub(b_sub),
    .sign(b_sign), .exp(b_exp), .mant(b_mant)
  );

  // unpack: special-case detection and exponent difference
  logic              sgn;
  logic              za, zb;
  logic              spec_n;
  logic [15:0]       spec_val_n;
  logic signed [6:0] exp_n;

  assign sgn   = a_sign ^ b_sign;
  assign za    = a_zero | a_sub;
  assign zb    = b_zero | b_sub;
  assign exp_n = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + 7'sd15;

  always_comb begin
    spec_n     = 1'b1;
    spec_val_n = NAN_VALUE;
    if (a_nan || b_nan)                   spec_val_n = NAN_VALUE;
    else if ((za && zb) || (a_inf && b_inf)) spec_val_n = NAN_VALUE;
    else if (zb || a_inf)                 spec_val_n = {sgn, FP16_POS_INF[14:0]};
    else if (za || b_inf)                 spec_val_n = {sgn, 15'h0000};
    else begin
      spec_n     = 1'b0;
      spec_val_n = 16'h0000;
    end
  end

  // one restoring step; rem < 2*mb holds, so the shifted remainder fits 12 bits
  logic        rem_ge;
  logic [11:0] rem_sub;
  logic [11:0] rem_nxt;

  assign rem_ge  = (rem_q >= {1'b0, mb_q});
  assign rem_sub = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;
  assign rem_nxt = {rem_sub[10:0], 1'b0};

  // round: normalise, RNE on guard/sticky, then range check
  logic [13:0]       qn;
  logic signed [6:0] en;
  logic              guard, sticky, inc;
  logic [11:0]       mant_r;
  logic signed [6:0] e_fin;
  logic [9:0]        frac_fin;
  logic [15:0]       res_n;

  assign qn     = q_q[13] ? q_q : {q_q[12:0], 1'b0};
  assign en     = q_q[13] ? exp_q : (exp_q - 7'sd1);
  assign guard  = qn[2];
  assign sticky = (|qn[1:0]) | (|rem_q);
  assign inc    = guard & (sticky | qn[3]);
  assign mant_r = {1'b0, qn[13:3]} + {11'd0, inc};

  always_comb begin
    e_fin    = mant_r[11] ? (en + 7'sd1) : en;
    frac_fin = mant_r[11] ? 10'd0 : mant_r[9:0];
    if (spec_q)               res_n = spec_val_q;
    else if (e_fin >= 7'sd31) res_n = {sign_q, FP16_POS_INF[14:0]};
    else if (e_fin <= 7'sd0)  res_n = {sign_q, 15'h0000};
    else                      res_n = {sign_q, e_fin[4:0], frac_fin};
  end

  // the valid_out cycle is still busy, so a request there is dropped
  assign busy = (state != DIV_IDLE) | valid_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= DIV_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      mb_q       <= '0;
      rem_q      <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      result     <= '0;
      valid_out  <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        DIV_IDLE: begin
          if (valid_in && !valid_out) begin
            a_q   <= a;
            b_q   <= b;
            state <= DIV_UNPACK;
          end
        end
        DIV_UNPACK: begin
          sign_q     <= sgn;
          exp_q      <= exp_n;
          mb_q       <= b_mant;
          rem_q      <= {1'b0, a_mant};
          q_q        <= '0;
          spec_q     <= spec_n;
          spec_val_q <= spec_val_n;
          cnt_q      <= 4'd13;
          state      <= DIV_DIVIDE;
        end
        DIV_DIVIDE: begin
          q_q   <= {q_q[12:0], rem_ge};
          rem_q <= rem_nxt;
          if (cnt_q == 4'd0) state <= DIV_ROUND;
          else               cnt_q <= cnt_q - 4'd1;
        end
        DIV_ROUND: begin
          result    <= res_n;
          valid_out <= 1'b1;
          state     <= DIV_IDLE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_div_iterative.sv
// Randomised bench for fpu_div_iterative against an exact-rational FP16 model.
module tb_fpu_div_iterative;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [15:0] a, b;
  logic        valid_out;
  logic [15:0] result;
  logic        busy;

  int n_chk;
  int n_err;

  fpu_div_iterative dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .a(a), .b(b),
    .valid_out(valid_out), .result(result), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // quotient of the exact operand values, rounded to nearest even at 11 bits
  function automatic logic [15:0] ref_div(input logic [15:0] x, input logic [15:0] y);
    int ex, ey, fx, fy, ma, mb, e, n, q, r;
    logic s, zx, zy, ix, iy, nx, ny;
    logic [4:0] e5;
    logic [9:0] f10;
    ex = int'(x[14:10]); ey = int'(y[14:10]);
    fx = int'(x[9:0]);   fy = int'(y[9:0]);
    s  = x[15] ^ y[15];
    zx = (ex == 0); zy = (ey == 0);
    ix = (ex == 31) && (fx == 0); iy = (ey == 31) && (fy == 0);
    nx = (ex == 31) && (fx != 0); ny = (ey == 31) && (fy != 0);
    if (nx || ny) return 16'h7E00;
    if ((zx && zy) || (ix && iy)) return 16'h7E00;
    if (zy || ix) return {s, 15'h7C00};
    if (zx || iy) return {s, 15'h0000};
    ma = 1024 + fx; mb = 1024 + fy;
    e  = ex - ey + 15;
    if (ma >= mb) n = ma * 1024;
    else begin
      n = ma * 2048;
      e = e - 1;
    end
    q = n / mb; r = n % mb;
    if ((2 * r > mb) || ((2 * r == mb) && (q % 2 == 1))) q = q + 1;
    if (q == 2048) begin
      q = 1024;
      e = e + 1;
    end
    if (e >= 31) return {s, 15'h7C00};
    if (e <= 0)  return {s, 15'h0000};
    e5  = e[4:0];
    f10 = q[9:0];
    return {s, e5, f10};
  endfunction

  function automatic logic [15:0] rand_fp();
    int k;
    logic [15:0] v;
    k = $urandom_range(0, 11);
    v = 16'($urandom);
    case (k)
      0: v[14:0] = 15'h0000;
      1: v[14:0] = 15'h7C00;
      2: begin v[14:10] = 5'h1F; if (v[9:0] == 0) v[9] = 1'b1; end
      3: begin v[14:10] = 5'h00; if (v[9:0] == 0) v[0] = 1'b1; end
      default: v[14:10] = 5'($urandom_range(1, 30));
    endcase
    return v;
  endfunction

  // one full transaction with latency, busy window and pulse-width checks;
  // repulse>=0 re-asserts valid_in with a=4400 at that cycle of the op
  task automatic do_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] exp, input int repulse);
    int i;
    logic busy_ok;
    @(negedge clk);
    a = x; b = y; valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    i = 0;
    busy_ok = 1'b1;
    while (!valid_out && i < 40) begin
      if (!busy) busy_ok = 1'b0;
      if (i == repulse) begin
        a = 16'h4400; valid_in = 1'b1;
      end else valid_in = 1'b0;
      @(negedge clk);
      i++;
    end
    valid_in = 1'b0;
    chk({tag, "_lat"}, i, 16);
    chk({tag, "_res"}, result, exp);
    chk({tag, "_busy"}, {busy_ok, busy}, 2'b11);
    // request in the valid_out cycle must be dropped
    a = 16'h4400; b = 16'h3C00; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    chk({tag, "_pulse"}, {valid_out, busy}, 2'b00);
    chk({tag, "_hold"}, result, exp);
  endtask

  initial begin
    int vo_seen;
    logic [15:0] x, y;
    n_chk = 0; n_err = 0;
    rst_n = 1'b0; valid_in = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_state", {valid_out, busy, result}, 18'h0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("half",   16'h3C00, 16'h4000, 16'h3800, -1);
    do_op("third",  16'h3C00, 16'h4200, 16'h3555, -1);
    do_op("neg",    16'hC500, 16'h4000, 16'hC100, -1);
    do_op("divz",   16'h3C00, 16'h0000, 16'h7C00, -1);
    do_op("zz",     16'h0000, 16'h0000, 16'h7E00, -1);
    do_op("ovf",    16'h7BFF, 16'h0400, 16'h7C00, -1);
    do_op("unf",    16'h0400, 16'h7BFF, 16'h0000, -1);
    do_op("infinf", 16'hFC00, 16'h7C00, 16'h7E00, -1);
    do_op("nan",    16'h3C00, 16'h7E01, 16'h7E00, -1);
    do_op("subn",   16'h0001, 16'h3C00, 16'h0000, -1);
    do_op("repulse",16'h3C00, 16'h4000, 16'h3800, 5);

    // reset in the middle of an operation
    @(negedge clk);
    a = 16'h3C00; b = 16'h4000; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst", {valid_out, busy, result}, 18'h0);
    @(negedge clk);
    rst_n = 1'b1;
    vo_seen = 0;
    repeat (24) begin
      @(negedge clk);
      if (valid_out) vo_seen++;
    end
    chk("midrst_novo", vo_seen, 0);
    do_op("postrst", 16'h3C00, 16'h4000, 16'h3800, -1);

    for (int k = 0; k < 200; k++) begin
      x = rand_fp();
      y = rand_fp();
      do_op($sformatf("rnd%0d_%h_%h", k, x, y), x, y, ref_div(x, y), -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_div_iterative.md
Name: fpu_div_iterative

Overview:
- FP16 (IEEE 754 binary16) divider; computes a / b and produces one result per operation.
- Execution unit directly downstream of the FPU peripheral's operand/FSM stage. Fed when operation == DIV and state == OPERANDS_READY; its result is consumed in CALCULATING.
- Same valid_in / valid_out / result contract as the existing adder and multiplier units.
- Multi-cycle, not pipelined: one operation in flight.

Parameters:
- NAN_VALUE, 16'h7E00, canonical quiet NaN emitted for every invalid or NaN result.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- valid_in  input  1  start pulse; a/b sampled on this edge when idle
- a  input  16  dividend, FP16
- b  input  16  divisor, FP16
- valid_out  output  1  one-cycle pulse; result valid this cycle
- result  output  16  quotient, FP16; holds until next valid_out
- busy  output  1  high from the cycle after valid_in accept until the valid_out cycle inclusive

Behaviour:
- Reset (async, rst_n low): state=IDLE, valid_out=0, result=16'h0000, busy=0, all internal regs cleared. Reset mid-operation aborts silently; no valid_out follows.
- States: IDLE -> UNPACK -> DIVIDE -> ROUND -> IDLE.
- IDLE: valid_in=1 latches a, b -> UNPACK.
- UNPACK (1 cycle):
  - Classify operands (zero, inf, NaN, normal). Subnormal inputs are flushed to signed zero.
  - Sign = a[15]^b[15].
  - exp = ea - eb + 15, 7-bit signed.
  - Mantissas {1, frac} (11 bits).
  - Set special flag and special value.
  - -> DIVIDE with counter=13.
- DIVIDE (14 cycles): restoring division, one quotient bit per cycle, MSB first, 14-bit quotient q. Remainder width 12 bits. Counter decrements; at 0 -> ROUND.
- ROUND (1 cycle):
  - Normalise: if q[13]=0, shift q left 1 and exp -= 1.
  - Guard = next bit below the 11 result bits, sticky = OR(lower q bits, remainder != 0).
  - Round-to-nearest-even. On mantissa carry, exp += 1.
  - Register result, pulse valid_out, -> IDLE.
- Latency fixed at 16 cycles: valid_in sampled at edge N -> valid_out high in the cycle after edge N+16. Special cases use the same latency; the divide iterations still run and the result is overridden.
- Special cases (priority order):
  - either operand NaN -> NAN_VALUE
  - 0/0 or inf/inf -> NAN_VALUE
  - x/0 (x nonzero or inf) -> signed inf (sign<<15 | 16'h7C00)
  - inf/x -> signed inf
  - 0/x or x/inf -> signed zero
- Overflow: final exp >= 31 -> signed inf.
- Underflow: final exp <= 0 -> signed zero (flush-to-zero, no subnormal output).
- valid_in while busy=1 is ignored. Operands are not latched and no error is flagged. The upstream FSM guarantees a single request per operation.
- valid_in in the same cycle as valid_out (state returning to IDLE) is ignored. The request is accepted only when state==IDLE at the sampling edge.
- result is stable between valid_out pulses.
- Throughput: one operation per 17 cycles.

Decomposition:
- Shared package fpu_pkg holds:
  - FP16 field constants: EXP_W=5, FRAC_W=10, BIAS=15.
  - FP16_POS_INF=16'h7C00, FP16_QNAN=16'h7E00.
  - Operation enum: ADD..CONV.
  - Divider state enum: IDLE, UNPACK, DIVIDE, ROUND.
- The adder and multiplier migrate their constants to this package later.
- One sub-module, fpu_fp16_classify: combinational, 16-bit in -> is_zero, is_inf, is_nan, is_sub, sign, exp, mant. Instantiated twice. Reusable by the other units.

Test Plan:
- a=16'h3C00 (1.0), b=16'h4000 (2.0) -> exactly 16 cycles later valid_out=1 for one cycle, result=16'h3800 (0.5); busy high during that window.
- a=16'h3C00, b=16'h4200 (3.0) -> result=16'h3555 (RNE of 1/3).
- a=16'hC500 (-5.0), b=16'h4000 -> result=16'hC100 (-2.5).
- Specials:
  - 16'h3C00/16'h0000 -> 16'h7C00
  - 16'h0000/16'h0000 -> 16'h7E00
  - 16'h7BFF/16'h0400 -> 16'h7C00 (overflow)
  - 16'h0400/16'h7BFF -> 16'h0000 (underflow flush)
- valid_in re-pulsed with a=16'h4400 at cycle 5 of an op on 1.0/2.0 -> ignored, single valid_out with 16'h3800. rst_n low at cycle 8 of an op -> no valid_out, result=0, busy=0; next op after reset completes normally.
